// File: rtl/athos_xif_ctrl.sv
// athos_xif_ctrl: in-order instruction tracker and datapath sequencer for the ATHOS
// CUSTOM-0 extension. Accepted instructions wait in a circular slot buffer until the
// core commits or kills them; committed heads are run one at a time on the datapath
// and their results are returned in issue order.
// Optional feature: define ATHOS_CTRL_PERF_EN to build the performance counters.
module athos_xif_ctrl #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [ID_W-1:0]   issue_id_i,
  input  logic [31:0]       issue_instr_i,
  output logic              issue_accept_o,
  input  logic              commit_valid_i,
  input  logic [ID_W-1:0]   commit_id_i,
  input  logic              commit_kill_i,
  output logic              dp_start_o,
  output logic [31:0]       dp_instr_o,
  input  logic              dp_done_i,
  input  logic [DATA_W-1:0] dp_result_i,
  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic [ID_W-1:0]   result_id_o,
  output logic [DATA_W-1:0] result_data_o,
  output logic              busy_o,
  output logic [31:0]       perf_exec_cnt_o,
  output logic [31:0]       perf_kill_cnt_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {SlotIssued, SlotCommitted, SlotKilled} slot_e;
  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  logic [ID_W-1:0]   r_id    [DEPTH];
  logic [31:0]       r_instr [DEPTH];
  slot_e             r_slot  [DEPTH];
  logic [PtrW-1:0]   r_head, r_tail;
  logic [PtrW:0]     r_count;
  state_e            r_state, w_state_d;
  logic [DATA_W-1:0] r_result;

  logic              w_push, w_pop, w_start, w_capture, w_empty;
  logic              w_new_hit, w_found;
  logic [DEPTH-1:0]  w_hit;
  logic [PtrW-1:0]   w_idx;

  assign w_empty        = (r_count == '0);
  assign issue_ready_o  = (r_count < (PtrW+1)'(DEPTH));
  assign issue_accept_o = (issue_instr_i[6:0] == 7'b0001011);
  assign w_push         = issue_valid_i && issue_ready_o && issue_accept_o;

  // Commit target: a same-cycle issue of the same id wins, else the oldest ISSUED match.
  always_comb begin
    w_hit     = '0;
    w_found   = 1'b0;
    w_idx     = r_head;
    w_new_hit = w_push && commit_valid_i && (commit_id_i == issue_id_i);
    if (commit_valid_i && !w_new_hit) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        w_idx = r_head + PtrW'(k);
        if (!w_found && ((PtrW+1)'(k) < r_count) && (r_slot[w_idx] == SlotIssued) &&
            (r_id[w_idx] == commit_id_i)) begin
          w_hit[w_idx] = 1'b1;
          w_found      = 1'b1;
        end
      end
    end
  end

  // Slot contents: allocation at the tail and commit/kill status updates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_id[k]    <= '0;
        r_instr[k] <= '0;
        r_slot[k]  <= SlotIssued;
      end
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (w_hit[k]) r_slot[k] <= commit_kill_i ? SlotKilled : SlotCommitted;
      end
      if (w_push) begin
        r_id[r_tail]    <= issue_id_i;
        r_instr[r_tail] <= issue_instr_i;
        r_slot[r_tail]  <= w_new_hit ? (commit_kill_i ? SlotKilled : SlotCommitted)
                                     : SlotIssued;
      end
    end
  end

  // Head/tail pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PtrW'(w_pop);
      r_tail  <= r_tail + PtrW'(w_push);
      r_count <= r_count + (PtrW+1)'(w_push) - (PtrW+1)'(w_pop);
    end
  end

  // Sequencer next state: start committed heads, drop killed heads, return results.
  always_comb begin
    w_state_d = r_state;
    w_pop     = 1'b0;
    w_start   = 1'b0;
    w_capture = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          if (r_slot[r_head] == SlotCommitted) begin
            w_start   = 1'b1;
            w_state_d = StExec;
          end else if (r_slot[r_head] == SlotKilled) begin
            w_pop = 1'b1;
          end
        end
      end
      StExec: begin
        if (dp_done_i) begin
          w_capture = 1'b1;
          w_state_d = StResp;
        end
      end
      StResp: begin
        if (result_ready_i) begin
          w_pop     = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Sequencer state and captured datapath result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= StIdle;
      r_result <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_capture) r_result <= dp_result_i;
    end
  end

  assign dp_start_o     = w_start;
  assign dp_instr_o     = (w_start || (r_state == StExec)) ? r_instr[r_head] : '0;
  assign result_valid_o = (r_state == StResp);
  assign result_id_o    = result_valid_o ? r_id[r_head] : '0;
  assign result_data_o  = result_valid_o ? r_result : '0;
  assign busy_o         = !w_empty || (r_state != StIdle);

`ifdef ATHOS_CTRL_PERF_EN
  logic [31:0] r_exec_cnt, r_kill_cnt;

  // Count result handshakes and killed-slot drops; both wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_exec_cnt <= '0;
      r_kill_cnt <= '0;
    end else begin
      if (w_pop && (r_state == StResp)) r_exec_cnt <= r_exec_cnt + 32'd1;
      if (w_pop && (r_state == StIdle)) r_kill_cnt <= r_kill_cnt + 32'd1;
    end
  end

  assign perf_exec_cnt_o = r_exec_cnt;
  assign perf_kill_cnt_o = r_kill_cnt;
`else
  assign perf_exec_cnt_o = '0;
  assign perf_kill_cnt_o = '0;
`endif

endmodule

// File: tb/tb_athos_xif_ctrl.sv
// Self-checking bench for athos_xif_ctrl: opcode decode table, directed multi-cycle
// sequences, and a randomized run against a queue-based in-order reference model.
`timescale 1ns/1ps
module tb_athos_xif_ctrl;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned DATA_W = 32;
  localparam int StI = 0, StC = 1, StK = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              issue_valid_i, issue_ready_o, issue_accept_o;
  logic [ID_W-1:0]   issue_id_i;
  logic [31:0]       issue_instr_i;
  logic              commit_valid_i, commit_kill_i;
  logic [ID_W-1:0]   commit_id_i;
  logic              dp_start_o, dp_done_i;
  logic [31:0]       dp_instr_o;
  logic [DATA_W-1:0] dp_result_i;
  logic              result_valid_o, result_ready_i, busy_o;
  logic [ID_W-1:0]   result_id_o;
  logic [DATA_W-1:0] result_data_o;
  logic [31:0]       perf_exec_cnt_o, perf_kill_cnt_o;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct { logic [31:0] instr; logic acc; } vec_t;
  typedef struct { logic [ID_W-1:0] id; logic [31:0] instr; int st; } ent_t;

  ent_t        mq[$];
  int          exec_busy, pend, hs_cnt, kill_cnt;
  logic [31:0] exp_data;
  logic [ID_W-1:0] next_id;

  always #5 clk_i = ~clk_i;

  athos_xif_ctrl #(.DEPTH(DEPTH), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_id_i(issue_id_i), .issue_instr_i(issue_instr_i), .issue_accept_o(issue_accept_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .dp_start_o(dp_start_o), .dp_instr_o(dp_instr_o),
    .dp_done_i(dp_done_i), .dp_result_i(dp_result_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o),
    .busy_o(busy_o), .perf_exec_cnt_o(perf_exec_cnt_o), .perf_kill_cnt_o(perf_kill_cnt_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: condition not met", name);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] cinstr(input logic [ID_W-1:0] id);
    return 32'h0000_000B | (32'(id) << 20);
  endfunction

  task automatic idle_inputs();
    issue_valid_i = 0; issue_id_i = '0; issue_instr_i = '0;
    commit_valid_i = 0; commit_id_i = '0; commit_kill_i = 0;
    dp_done_i = 0; dp_result_i = '0; result_ready_i = 0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk1({tag, "_start"}, dp_start_o, 1'b0);
    chk1({tag, "_rvalid"}, result_valid_o, 1'b0);
    chk({tag, "_rid"}, 32'(result_id_o), 32'd0);
    chk({tag, "_rdata"}, result_data_o, 32'd0);
    chk1({tag, "_busy"}, busy_o, 1'b0);
    chk1({tag, "_ready"}, issue_ready_o, 1'b1);
    chk({tag, "_dpinstr"}, dp_instr_o, 32'd0);
    chk({tag, "_pexec"}, perf_exec_cnt_o, 32'd0);
    chk({tag, "_pkill"}, perf_kill_cnt_o, 32'd0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 0;
    #1;
    chk_reset_outs("rst");
    tick();
    rst_ni = 1;
    tick();
  endtask

  task automatic issue(input logic [ID_W-1:0] id, input logic [31:0] instr);
    int t = 0;
    issue_valid_i = 1; issue_id_i = id; issue_instr_i = instr;
    while (!issue_ready_o && t < 50) begin tick(); t++; end
    if (t >= 50) fail("issue_timeout");
    tick();
    issue_valid_i = 0;
  endtask

  task automatic commit(input logic [ID_W-1:0] id, input logic kill);
    commit_valid_i = 1; commit_id_i = id; commit_kill_i = kill;
    tick();
    commit_valid_i = 0; commit_kill_i = 0;
  endtask

  task automatic wait_start(input string name);
    int t = 0;
    while (!dp_start_o && t < 20) begin tick(); t++; end
    if (t >= 20) fail(name);
  endtask

  // One randomized cycle; model updates mirror what the DUT will see at the next edge.
  task automatic rand_cycle(input bit draining);
    int cand[$];
    int pick;
    logic [31:0] ri;
    dp_done_i = 0;
    if (dp_start_o) begin
      if (exec_busy != 0) fail("rnd_start_overlap");
      while (mq.size() > 0 && mq[0].st == StK) void'(mq.pop_front());
      if (mq.size() == 0 || mq[0].st != StC) fail("rnd_start_head");
      else chk("rnd_dp_instr", dp_instr_o, mq[0].instr);
      exec_busy = 1;
      pend = $urandom_range(1, 3);
      exp_data = $urandom;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin dp_done_i = 1; dp_result_i = exp_data; end
    end
    result_ready_i = 0;
    if (result_valid_o) begin
      if (exec_busy == 0 || mq.size() == 0) fail("rnd_result_unexpected");
      else begin
        chk("rnd_rid", 32'(result_id_o), 32'(mq[0].id));
        chk("rnd_rdata", result_data_o, exp_data);
      end
      result_ready_i = draining ? 1'b1 : 1'($urandom_range(0, 1));
      if (result_ready_i && exec_busy != 0 && mq.size() > 0) begin
        void'(mq.pop_front());
        exec_busy = 0;
        hs_cnt++;
      end
    end
    commit_valid_i = 0; commit_kill_i = 0;
    for (int i = 0; i < mq.size(); i++) if (mq[i].st == StI) cand.push_back(i);
    if (cand.size() > 0 && (draining || $urandom_range(0, 99) < 30)) begin
      pick = cand[$urandom_range(0, cand.size() - 1)];
      commit_valid_i = 1;
      commit_id_i = mq[pick].id;
      commit_kill_i = draining ? 1'b0 : ($urandom_range(0, 3) == 0);
      mq[pick].st = commit_kill_i ? StK : StC;
      if (commit_kill_i) kill_cnt++;
    end
    ri = $urandom;
    if ($urandom_range(0, 1) == 1) ri[6:0] = 7'b0001011;
    issue_valid_i = !draining && ($urandom_range(0, 99) < 60);
    issue_id_i = next_id;
    issue_instr_i = ri;
    #1;
    chk1("rnd_accept", issue_accept_o, ri[6:0] == 7'b0001011);
    if (issue_valid_i && issue_ready_o && issue_accept_o) begin
      mq.push_back('{id: next_id, instr: ri, st: StI});
      next_id++;
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    vec_t tbl[7];
    int starts, results, live;
    logic [31:0] i6;

    idle_inputs();
    #2;
    do_reset();

    // Opcode decode table (no valid, so nothing is allocated).
    tbl[0] = '{32'h0000_000B, 1'b1};
    tbl[1] = '{32'h0000_0033, 1'b0};
    tbl[2] = '{32'hFFFF_FF8B, 1'b1};
    tbl[3] = '{32'h0000_002B, 1'b0};
    tbl[4] = '{32'h0000_000A, 1'b0};
    tbl[5] = '{32'h0000_004B, 1'b0};
    tbl[6] = '{32'h1234_560B, 1'b1};
    for (int i = 0; i < 7; i++) begin
      issue_instr_i = tbl[i].instr;
      #1;
      chk1($sformatf("tbl_accept_%0d", i), issue_accept_o, tbl[i].acc);
      chk1($sformatf("tbl_busy_%0d", i), busy_o, 1'b0);
    end

    // Basic execute: id 3, done two cycles after start.
    do_reset();
    issue(4'd3, cinstr(4'd3));
    commit(4'd3, 1'b0);
    chk1("e2e_start", dp_start_o, 1'b1);
    chk("e2e_instr", dp_instr_o, cinstr(4'd3));
    tick();
    chk1("e2e_start_once_a", dp_start_o, 1'b0);
    chk("e2e_instr_hold", dp_instr_o, cinstr(4'd3));
    tick();
    chk1("e2e_start_once_b", dp_start_o, 1'b0);
    dp_done_i = 1; dp_result_i = 32'hDEAD_BEEF;
    tick();
    dp_done_i = 0;
    chk1("e2e_rvalid", result_valid_o, 1'b1);
    chk("e2e_rid", 32'(result_id_o), 32'd3);
    chk("e2e_rdata", result_data_o, 32'hDEAD_BEEF);
    chk1("e2e_start_once_c", dp_start_o, 1'b0);
    result_ready_i = 1;
    tick();
    result_ready_i = 0;
    chk1("e2e_rvalid_clr", result_valid_o, 1'b0);
    chk1("e2e_busy_clr", busy_o, 1'b0);

    // Non-ATHOS opcode is never allocated.
    do_reset();
    issue_valid_i = 1; issue_id_i = 4'd2; issue_instr_i = 32'h0000_0033;
    #1;
    chk1("nonathos_accept", issue_accept_o, 1'b0);
    tick();
    issue_valid_i = 0;
    for (int i = 0; i < 3; i++) begin
      chk1("nonathos_busy", busy_o, 1'b0);
      chk1("nonathos_start", dp_start_o, 1'b0);
      tick();
    end

    // Full buffer stalls issue until the head is returned.
    do_reset();
    for (int i = 1; i <= 4; i++) issue(4'(i), cinstr(4'(i)));
    chk1("full_ready", issue_ready_o, 1'b0);
    issue_valid_i = 1; issue_id_i = 4'd5; issue_instr_i = cinstr(4'd5);
    tick(); tick();
    chk1("full_stall", issue_ready_o, 1'b0);
    commit(4'd1, 1'b0);
    wait_start("full_start_timeout");
    chk("full_dp_instr", dp_instr_o, cinstr(4'd1));
    tick();
    dp_done_i = 1; dp_result_i = 32'h0000_0111;
    tick();
    dp_done_i = 0;
    chk1("full_rvalid", result_valid_o, 1'b1);
    chk("full_rid", 32'(result_id_o), 32'd1);
    chk1("full_ready_still0", issue_ready_o, 1'b0);
    result_ready_i = 1;
    tick();
    result_ready_i = 0;
    chk1("full_ready_back", issue_ready_o, 1'b1);
    tick();
    issue_valid_i = 0;
    chk1("full_refill", issue_ready_o, 1'b0);

    // Kill 5, commit 6: only 6 executes.
    do_reset();
    i6 = cinstr(4'd6) | 32'h0000_5000;
    issue(4'd5, cinstr(4'd5));
    issue(4'd6, i6);
    commit(4'd5, 1'b1);
    commit(4'd6, 1'b0);
    starts = 0; results = 0; pend = 0;
    for (int c = 0; c < 30; c++) begin
      dp_done_i = 0; result_ready_i = 0;
      if (dp_start_o) begin
        starts++;
        chk("kill_dp_instr", dp_instr_o, i6);
        pend = 1;
      end else if (pend == 1) begin
        dp_done_i = 1; dp_result_i = 32'hCAFE_0006; pend = 0;
      end
      if (result_valid_o) begin
        chk("kill_rid", 32'(result_id_o), 32'd6);
        chk("kill_rdata", result_data_o, 32'hCAFE_0006);
        result_ready_i = 1;
        results++;
      end
      tick();
    end
    result_ready_i = 0;
    chk("kill_starts", 32'(starts), 32'd1);
    chk("kill_results", 32'(results), 32'd1);
`ifdef ATHOS_CTRL_PERF_EN
    chk("kill_perf_kill", perf_kill_cnt_o, 32'd1);
    chk("kill_perf_exec", perf_exec_cnt_o, 32'd1);
`else
    chk("kill_perf_kill", perf_kill_cnt_o, 32'd0);
    chk("kill_perf_exec", perf_exec_cnt_o, 32'd0);
`endif

    // Back-pressure on the result: held stable, next head waits.
    do_reset();
    issue(4'd7, cinstr(4'd7));
    issue(4'd8, cinstr(4'd8));
    commit(4'd8, 1'b0);
    commit(4'd7, 1'b0);
    wait_start("hold_start_timeout");
    chk("hold_dp_instr7", dp_instr_o, cinstr(4'd7));
    tick();
    dp_done_i = 1; dp_result_i = 32'h1234_5678;
    tick();
    dp_done_i = 0;
    for (int i = 0; i < 5; i++) begin
      chk1("hold_rvalid", result_valid_o, 1'b1);
      chk("hold_rid", 32'(result_id_o), 32'd7);
      chk("hold_rdata", result_data_o, 32'h1234_5678);
      chk1("hold_no_start", dp_start_o, 1'b0);
      tick();
    end
    result_ready_i = 1;
    tick();
    result_ready_i = 0;
    chk1("hold_next_start", dp_start_o, 1'b1);
    chk("hold_dp_instr8", dp_instr_o, cinstr(4'd8));

    // Reset while executing discards the instruction.
    do_reset();
    issue(4'd9, cinstr(4'd9));
    commit(4'd9, 1'b0);
    chk1("rexec_start", dp_start_o, 1'b1);
    tick();
    chk1("rexec_busy", busy_o, 1'b1);
    chk("rexec_instr_hold", dp_instr_o, cinstr(4'd9));
    rst_ni = 0;
    #1;
    chk_reset_outs("rexec");
    tick();
    rst_ni = 1;
    dp_done_i = 1; dp_result_i = 32'hBAD0_BAD0;
    tick();
    dp_done_i = 0;
    for (int i = 0; i < 4; i++) begin
      chk1("rexec_no_result", result_valid_o, 1'b0);
      chk1("rexec_no_start", dp_start_o, 1'b0);
      chk1("rexec_idle", busy_o, 1'b0);
      tick();
    end

    // Randomized run against the in-order queue model, then drain.
    do_reset();
    mq.delete();
    exec_busy = 0; pend = 0; hs_cnt = 0; kill_cnt = 0; exp_data = '0; next_id = '0;
    for (int c = 0; c < 1500; c++) rand_cycle(1'b0);
    for (int c = 0; c < 300; c++) begin
      live = 0;
      foreach (mq[i]) if (mq[i].st != StK) live++;
      if (!busy_o && exec_busy == 0 && live == 0 && pend == 0) break;
      rand_cycle(1'b1);
    end
    live = 0;
    foreach (mq[i]) if (mq[i].st != StK) live++;
    chk("rnd_drained", 32'(live), 32'd0);
    chk1("rnd_busy_end", busy_o, 1'b0);
    chk1("rnd_ready_end", issue_ready_o, 1'b1);
`ifdef ATHOS_CTRL_PERF_EN
    chk("rnd_perf_exec", perf_exec_cnt_o, 32'(hs_cnt));
    chk("rnd_perf_kill", perf_kill_cnt_o, 32'(kill_cnt));
`else
    chk("rnd_perf_exec", perf_exec_cnt_o, 32'd0);
    chk("rnd_perf_kill", perf_kill_cnt_o, 32'd0);
`endif
    if (hs_cnt == 0) fail("rnd_no_results");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/athos_xif_ctrl.md
ATHOS_XIF_CTRL -- requirements
Module: athos_xif_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, in-flight instruction slots (power of 2, >=2).
REQ-002 SHALL have parameter ID_W, default 4, instruction id width.
REQ-003 SHALL have parameter DATA_W, default 32, result width.
REQ-004 SHALL have ports, one clock, reset asynchronous active-low:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- issue_valid_i  in  1  issue request
- issue_ready_o  out  1  slot free
- issue_id_i  in  ID_W  issue id
- issue_instr_i  in  32  instruction word
- issue_accept_o  out  1  instruction is ATHOS (valid with handshake)
- commit_valid_i  in  1  commit/kill strobe
- commit_id_i  in  ID_W  committed id
- commit_kill_i  in  1  1=kill, 0=commit
- dp_start_o  out  1  one-cycle datapath start pulse
- dp_instr_o  out  32  instruction to datapath
- dp_done_i  in  1  datapath completion pulse
- dp_result_i  in  DATA_W  datapath result
- result_valid_o  out  1  result available
- result_ready_i  in  1  core accepts result
- result_id_o  out  ID_W  result id
- result_data_o  out  DATA_W  result data
- busy_o  out  1  any slot occupied or FSM not IDLE
- perf_exec_cnt_o  out  32  executed-instruction count
- perf_kill_cnt_o  out  32  killed-instruction count

Function
REQ-005 issue_ready_o SHALL be 1 iff occupancy < DEPTH; no same-cycle pop bypass.
REQ-006 issue_accept_o SHALL be 1 iff issue_instr_i[6:0]==7'b0001011 (CUSTOM-0).
REQ-007 Handshake (valid&ready) with accept=1 SHALL allocate tail slot {id, instr, state=ISSUED}; accept=0 allocates nothing.
REQ-008 Commit strobe SHALL set matching ISSUED slot to COMMITTED (kill=0) or KILLED (kill=1); no match ignored.
REQ-009 Commit in same cycle as accepted issue of same id SHALL apply to the new slot.
REQ-010 FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-011 IDLE: head COMMITTED -> dp_start_o=1 for exactly one cycle, dp_instr_o=head instr, go EXEC; head KILLED -> pop head, stay IDLE; head ISSUED or empty -> stay IDLE.
REQ-012 EXEC: on dp_done_i capture dp_result_i, go RESP; dp_done_i in same cycle as start is ignored.
REQ-013 RESP: result_valid_o=1, result_id_o=head id, result_data_o=captured value, held stable until result_ready_i; on handshake pop head, go IDLE.
REQ-014 Minimum latency committed head -> result_valid_o: start cycle + 1 cycle after dp_done_i.
REQ-015 Results SHALL be returned strictly in issue order; pointers wrap modulo DEPTH.
REQ-016 Kill of head during EXEC/RESP SHALL be ignored (slot already executing).
REQ-017 dp_instr_o SHALL hold head instr through EXEC.

Reset
REQ-018 rst_ni low SHALL asynchronously clear all slots, pointers, FSM to IDLE, counters to 0.
REQ-019 During reset: dp_start_o=0, result_valid_o=0, result_id_o=0, result_data_o=0, busy_o=0, issue_ready_o=1, dp_instr_o=0.
REQ-020 Reset mid-EXEC SHALL discard the instruction; subsequent dp_done_i ignored in IDLE.

Configuration
REQ-021 Macro ATHOS_CTRL_PERF_EN defined: perf_exec_cnt_o increments per result handshake, perf_kill_cnt_o per KILLED pop, both wrap at 2^32.
REQ-022 ATHOS_CTRL_PERF_EN undefined: perf ports present, driven 0, no counter flops.

Verification
REQ-023 Issue id=3 CUSTOM-0, commit id=3, dp_done 2 cycles after start with 0xDEADBEEF -> one dp_start pulse, result id=3 data=0xDEADBEEF.
REQ-024 Issue opcode 7'b0110011 -> issue_accept_o=0, busy_o stays 0, no dp_start.
REQ-025 Issue ids 1,2,3,4 without commit -> issue_ready_o=0; fifth issue stalls; commit 1 and complete -> ready returns 1.
REQ-026 Issue 5,6; kill 5, commit 6 -> no execution of 5, result id=6 only; perf_kill_cnt_o=1 with macro, 0 without.
REQ-027 Result held with result_ready_i=0 for 5 cycles -> id/data stable; next head not started.
REQ-028 Assert rst_ni low during EXEC -> outputs per REQ-019; late dp_done_i produces no result.
